// File: rtl/pe_tile_driver.sv
// Gemmini PE transmit driver: expands a tile command into a preload beat plus K compute beats,
// and collects the PE's final per-tile result into a small credit-limited result FIFO.
module pe_tile_driver #(
  parameter int A_W       = 8,
  parameter int B_W       = 20,
  parameter int ID_W      = 3,
  parameter int SHIFT_W   = 5,
  parameter int LEN_W     = 8,
  parameter int RES_DEPTH = 4
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ID_W-1:0]    cmd_id,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [SHIFT_W-1:0] cmd_shift,
  input  logic               cmd_dataflow,
  input  logic [B_W-1:0]     cmd_d,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [A_W-1:0]     op_a,
  input  logic [B_W-1:0]     op_b,
  output logic               pe_in_valid,
  output logic [A_W-1:0]     pe_in_a,
  output logic [B_W-1:0]     pe_in_b,
  output logic [B_W-1:0]     pe_in_d,
  output logic               pe_in_dataflow,
  output logic               pe_in_propagate,
  output logic [SHIFT_W-1:0] pe_in_shift,
  output logic [ID_W-1:0]    pe_in_id,
  output logic               pe_in_last,
  input  logic               pe_out_valid,
  input  logic [B_W-1:0]     pe_out_c,
  input  logic [ID_W-1:0]    pe_out_id,
  input  logic               pe_out_last,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [B_W-1:0]     res_c,
  output logic [ID_W-1:0]    res_id,
  output logic               err_overflow
);

  localparam int CNT_W = $clog2(RES_DEPTH + 1);
  localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RES_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RES_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRELOAD = 2'd1,
    ST_COMPUTE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [ID_W-1:0]    id_reg;
  logic [LEN_W-1:0]   len_reg;
  logic [SHIFT_W-1:0] shift_reg;
  logic               dataflow_reg;
  logic [B_W-1:0]     d_reg;
  logic               prop_reg;
  logic [LEN_W-1:0]   beat_cnt_reg;
  logic [CNT_W-1:0]   outstanding_reg;

  logic               cmd_fire;
  logic               op_fire;
  logic               credit_ok;
  logic [LEN_W-1:0]   eff_len;
  logic [LEN_W-1:0]   beat_cnt_inc;
  logic               beat_last;

  logic [B_W-1:0]     mem_c  [RES_DEPTH];
  logic [ID_W-1:0]    mem_id [RES_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic               wr_en;

  // A zero-length command still carries one compute beat.
  assign eff_len      = (len_reg == '0) ? LEN_W'(1) : len_reg;
  assign beat_cnt_inc = beat_cnt_reg + LEN_W'(1);
  assign beat_last    = (beat_cnt_inc == eff_len);
  assign credit_ok    = (outstanding_reg < DEPTH_C);

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    op_ready   = 1'b0;
    cmd_fire   = 1'b0;
    op_fire    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cmd_ready = credit_ok;
        if (cmd_valid && credit_ok) begin
          cmd_fire   = 1'b1;
          state_next = ST_PRELOAD;
        end
      end
      ST_PRELOAD: state_next = ST_COMPUTE;
      ST_COMPUTE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          op_fire = 1'b1;
          if (beat_last) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      id_reg          <= '0;
      len_reg         <= '0;
      shift_reg       <= '0;
      dataflow_reg    <= 1'b0;
      d_reg           <= '0;
      prop_reg        <= 1'b0;
      beat_cnt_reg    <= '0;
      pe_in_valid     <= 1'b0;
      pe_in_a         <= '0;
      pe_in_b         <= '0;
      pe_in_d         <= '0;
      pe_in_dataflow  <= 1'b0;
      pe_in_propagate <= 1'b0;
      pe_in_shift     <= '0;
      pe_in_id        <= '0;
      pe_in_last      <= 1'b0;
    end else begin
      // Payload holds through bubbles; only the valid strobe drops.
      pe_in_valid <= 1'b0;
      if (cmd_fire) begin
        id_reg       <= cmd_id;
        len_reg      <= cmd_len;
        shift_reg    <= cmd_shift;
        dataflow_reg <= cmd_dataflow;
        d_reg        <= cmd_d;
        prop_reg     <= ~prop_reg;
      end
      if (state_reg == ST_PRELOAD) begin
        pe_in_valid     <= 1'b1;
        pe_in_a         <= '0;
        pe_in_b         <= '0;
        pe_in_d         <= d_reg;
        pe_in_dataflow  <= dataflow_reg;
        pe_in_propagate <= prop_reg;
        pe_in_shift     <= shift_reg;
        pe_in_id        <= id_reg;
        pe_in_last      <= 1'b0;
        beat_cnt_reg    <= '0;
      end
      if (op_fire) begin
        pe_in_valid     <= 1'b1;
        pe_in_a         <= op_a;
        pe_in_b         <= op_b;
        pe_in_d         <= '0;
        pe_in_dataflow  <= dataflow_reg;
        pe_in_propagate <= prop_reg;
        pe_in_shift     <= shift_reg;
        pe_in_id        <= id_reg;
        pe_in_last      <= beat_last;
        beat_cnt_reg    <= beat_cnt_inc;
      end
    end
  end

  // Outstanding credits count accepted tiles whose result has not yet been popped.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_reg <= '0;
    end else begin
      case ({cmd_fire, pop})
        2'b10:   outstanding_reg <= outstanding_reg + CNT_W'(1);
        2'b01:   if (outstanding_reg != '0) outstanding_reg <= outstanding_reg - CNT_W'(1);
        default: outstanding_reg <= outstanding_reg;
      endcase
    end
  end

  assign fifo_full = (count_reg == DEPTH_C);
  assign push      = pe_out_valid && pe_out_last;
  assign pop       = (count_reg != '0) && res_ready;
  assign wr_en     = push && (!fifo_full || pop);

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_c[wr_ptr_reg]  <= pe_out_c;
      mem_id[wr_ptr_reg] <= pe_out_id;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
      if (pop)   rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      if (push && fifo_full && !pop) err_overflow <= 1'b1;
    end
  end

  assign res_valid = (count_reg != '0);
  assign res_c     = mem_c[rd_ptr_reg];
  assign res_id    = mem_id[rd_ptr_reg];

endmodule
